// File: rtl/aes_req_pkg.sv
// Shared types and widths for the AES engine requester.
// Optional statistics counters are enabled by AES_REQ_STATS_EN.
package aes_req_pkg;

    localparam int BLOCK_W = 128;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } req_state_e;

endpackage

// File: rtl/aes_result_fifo.sv
// Synchronous result FIFO; head reads as zero when empty.
// Storage is not reset; only pointers and count are.
module aes_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [CNT_W-1:0]  o_count,
    output logic [DATA_W-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    // A pop against an empty FIFO is simply ignored.
    assign w_pop   = i_pop & (r_count != '0);
    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/aes_engine_requester.sv
// Issues blocks to the AES engine and buffers its results with credits.
// Define AES_REQ_STATS_EN to add issued_cnt / done_cnt outputs.
module aes_engine_requester
    import aes_req_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_encrypt,
    output logic               in_ready,
    output logic               eng_is_valid,
    output logic [BLOCK_W-1:0] eng_data_in,
    output logic               eng_encrypt_flag,
    input  logic               eng_busy,
    input  logic               eng_ready,
    input  logic [BLOCK_W-1:0] eng_data_out,
    output logic               out_valid,
    output logic [BLOCK_W-1:0] out_data,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   outstanding,
    output logic               idle,
    output logic               err_spurious
`ifdef AES_REQ_STATS_EN
    ,
    output logic [STAT_W-1:0]  issued_cnt,
    output logic [STAT_W-1:0]  done_cnt
`endif
);

    req_state_e         r_state;
    req_state_e         w_next_state;
    logic               r_eng_is_valid;
    logic [BLOCK_W-1:0] r_eng_data_in;
    logic               r_eng_encrypt;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_err_spurious;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W:0]     w_committed;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_result;
    logic               w_spurious;

    // Every issued block owns a FIFO slot until popped, so a push can never overflow.
    assign w_committed = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit_ok = w_committed < (CNT_W + 1)'(RES_DEPTH);

    assign in_ready   = (r_state == IDLE) & ~eng_busy & w_credit_ok;
    assign w_issue    = in_valid & in_ready;
    assign w_result   = eng_ready & (r_outstanding != '0);
    assign w_spurious = eng_ready & (r_outstanding == '0);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_issue) w_next_state = ISSUE;
            ISSUE:   w_next_state = GAP;
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= IDLE;
            r_eng_is_valid <= 1'b0;
            r_eng_data_in  <= '0;
            r_eng_encrypt  <= 1'b0;
            r_outstanding  <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_eng_is_valid <= w_issue;
            if (w_issue) begin
                r_eng_data_in <= in_data;
                r_eng_encrypt <= in_encrypt;
            end
            unique case ({w_issue, w_result})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

`ifdef AES_REQ_STATS_EN
    logic [STAT_W-1:0] r_issued_cnt;
    logic [STAT_W-1:0] r_done_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_issued_cnt <= '0;
            r_done_cnt   <= '0;
        end else begin
            if (w_issue) begin
                r_issued_cnt <= r_issued_cnt + STAT_W'(1);
            end
            if (w_result) begin
                r_done_cnt <= r_done_cnt + STAT_W'(1);
            end
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign done_cnt   = r_done_cnt;
`endif

    aes_result_fifo #(
        .DEPTH  (RES_DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W (BLOCK_W)
    ) u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_push      (w_result),
        .i_push_data (eng_data_out),
        .i_pop       (out_ready),
        .o_count     (w_fifo_count),
        .o_head      (out_data)
    );

    assign eng_is_valid     = r_eng_is_valid;
    assign eng_data_in      = r_eng_data_in;
    assign eng_encrypt_flag = r_eng_encrypt;
    assign out_valid        = (w_fifo_count != '0);
    assign outstanding      = r_outstanding;
    assign err_spurious     = r_err_spurious;
    assign idle = (r_state == IDLE) & (r_outstanding == '0) & (w_fifo_count == '0);

endmodule

// File: doc/aes_engine_requester.md
Name: aes_engine_requester

Overview:
- Initiator-side companion to the three-core AES engine. Sits between the XEX tweak logic and the engine.
- Accepts 128-bit blocks over a valid/ready handshake and issues them to the engine's is_valid/busy interface.
- Tracks blocks in flight and captures every engine ready pulse into a result FIFO, which drains downstream over valid/ready.
- Credit accounting guarantees no engine result is ever dropped; the engine has no output backpressure.

Parameters:
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2); also the credit limit.
- CNT_W, 3, width of the outstanding and FIFO-count fields; must hold RES_DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- in_valid  in  1  upstream block valid
- in_data  in  128  upstream plaintext/ciphertext block
- in_encrypt  in  1  1=encrypt, 0=decrypt, for this block
- in_ready  out  1  requester accepts block this cycle
- eng_is_valid  out  1  registered issue strobe to engine
- eng_data_in  out  128  registered block to engine
- eng_encrypt_flag  out  1  registered direction to engine
- eng_busy  in  1  engine busy_out
- eng_ready  in  1  engine result strobe, one cycle per result
- eng_data_out  in  128  engine result, valid when eng_ready=1
- out_valid  out  1  result FIFO non-empty
- out_data  out  128  FIFO head
- out_ready  in  1  downstream pops head
- outstanding  out  CNT_W  blocks issued, result not yet seen
- idle  out  1  state IDLE, outstanding=0, FIFO empty
- err_spurious  out  1  sticky: eng_ready seen with outstanding=0

Behaviour:
Reset (async, n_rst=0) clears:
- state=IDLE; eng_is_valid, eng_data_in, eng_encrypt_flag=0; outstanding=0; FIFO empty.
- out_valid=0, out_data=0, err_spurious=0, idle=1.
- Reset mid-operation discards in-flight and FIFO contents without emitting anything.

FSM states: IDLE, ISSUE, GAP.
- credit_ok = (outstanding + fifo_count) < RES_DEPTH.
- in_ready = (state==IDLE) & ~eng_busy & credit_ok. Combinational; it must not depend on in_valid.
- IDLE -> ISSUE on in_valid & in_ready. That edge registers in_data and in_encrypt into eng_data_in and eng_encrypt_flag, sets eng_is_valid=1, and increments outstanding.
- ISSUE -> GAP unconditionally. eng_is_valid is high exactly this one cycle; it clears on leaving ISSUE. eng_data_in holds its value until the next issue.
- GAP -> IDLE unconditionally. The mandatory bubble lets eng_busy reflect the new job, so a stale busy=0 never causes a double issue.
- Peak issue rate: one block per 3 cycles.

Result capture:
- eng_ready=1 with outstanding>0: push eng_data_out, outstanding decrements.
- eng_ready=1 with outstanding=0: drop the data, set err_spurious (sticky until reset).
- Issue and eng_ready on the same edge: outstanding unchanged.
- Credits make a push into a full FIFO impossible. No overflow path exists.

Output:
- out_valid = fifo_count!=0; out_data = head, 0 when empty.
- Pop on out_valid & out_ready.
- Simultaneous push and pop: count unchanged, order preserved (FIFO order equals engine completion order).
- Pop from empty is ignored.
- Pointers wrap modulo RES_DEPTH.

Optional Feature:
- Macro: AES_REQ_STATS_EN.
- Defined: adds outputs issued_cnt[15:0] and done_cnt[15:0].
  - issued_cnt increments on each issue; done_cnt on each non-spurious eng_ready.
  - Both wrap 0xFFFF->0 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package aes_req_pkg: BLOCK_W=128, state enum typedef (IDLE/ISSUE/GAP), STAT_W=16.
- Sub-module aes_result_fifo: synchronous FIFO parameterised by depth, with push/pop/count/head.
- The top holds the FSM, credit logic and error flag.

Test Plan:
- Single block: in_valid, in_data=128'h00112233445566778899AABBCCDDEEFF, in_encrypt=1, eng_busy=0. Required: eng_is_valid high exactly 1 cycle, 1 cycle after accept, with matching data and flag=1. Then eng_ready with 128'h69C4E0D86A7B0430D8CDB78070B4C55A gives out_valid next cycle with that data; idle=1 after pop.
- Back-pressure via credits: out_ready=0, 4 blocks issued, 4 results returned. Required: in_ready=0 while outstanding+count=4; 5th block held; in_ready returns 1 cycle after one pop.
- Busy stall: eng_busy=1 for 10 cycles with in_valid=1. Required: no eng_is_valid, in_ready=0 throughout; issue occurs on the first cycle busy=0.
- Simultaneous issue and eng_ready with outstanding=2. Required: outstanding stays 2; push and pop in the same cycle keep fifo count.
- Spurious ready: eng_ready=1 at outstanding=0. Required: err_spurious=1 and sticky, FIFO stays empty; assert n_rst mid-flight with 2 outstanding, then all outputs read reset values.
- With AES_REQ_STATS_EN: 3 issues, 3 results. Required: issued_cnt=3, done_cnt=3; a spurious ready leaves done_cnt=3.
